traffic_light_monitor: RTL and testbench

Passive checker on the lamp side of the traffic-light controller: samples the one-hot Red/Green/Yellow lamp drives every clock, tracks the phase sequence and measures each phase length against expected values. Flags illegal lamp encodings, out-of-order phases and short or long phases with a sticky error and code. Counts completed good Red→Green→Yellow cycles. Sits beside the controller in the top level and in the board bring-up harness.

---
 rtl/traffic_pkg.sv | 49 ++++
 rtl/phase_timer.sv | 32 +++
 rtl/traffic_light_monitor.sv | 171 +++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its lamp-side monitor:
// FSM state encoding, error codes, lamp encodings and default phase lengths.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACQ   = 3'd1,
    ST_CHK_R = 3'd2,
    ST_CHK_G = 3'd3,
    ST_CHK_Y = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_ENC   = 3'd1;
  localparam logic [2:0] ERR_ORDER = 3'd2;
  localparam logic [2:0] ERR_SHORT = 3'd3;
  localparam logic [2:0] ERR_LONG  = 3'd4;

  // Controller and monitor both take these, so the two ends cannot disagree.
  localparam int DEF_R_LEN = 4;
  localparam int DEF_G_LEN = 5;
  localparam int DEF_Y_LEN = 2;
  localparam int DEF_CW    = 4;

  // Lamp vector ordering is {Red, Green, Yellow}.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_G = 3'b010;
  localparam logic [2:0] LAMP_Y = 3'b001;

  function automatic logic [2:0] next_lamp(input logic [2:0] lamp);
    case (lamp)
      LAMP_R:  next_lamp = LAMP_G;
      LAMP_G:  next_lamp = LAMP_Y;
      LAMP_Y:  next_lamp = LAMP_R;
      default: next_lamp = 3'b000;
    endcase
  endfunction

  function automatic state_t chk_state(input logic [2:0] lamp);
    case (lamp)
      LAMP_R:  chk_state = ST_CHK_R;
      LAMP_G:  chk_state = ST_CHK_G;
      LAMP_Y:  chk_state = ST_CHK_Y;
      default: chk_state = ST_FAULT;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating phase-length counter: clear to 0, load to 1 on a new phase,
// otherwise count up while enabled and stick at all-ones.
module phase_timer #(
  parameter int CW = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic          i_inc,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] MAX_CNT = '1;

  logic [CW-1:0] r_count;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(1);
    end else if (i_inc && (r_count != MAX_CNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive lamp-side checker: validates one-hot encoding, R->G->Y order and
// per-phase lengths, latches the first fault and counts good cycles.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int R_LEN = DEF_R_LEN,
  parameter int G_LEN = DEF_G_LEN,
  parameter int Y_LEN = DEF_Y_LEN,
  parameter int CW    = DEF_CW
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Red,
  input  logic       Green,
  input  logic       Yellow,
  input  logic       Clear,
  output logic       Phase_Done,
  output logic       Error,
  output logic [2:0] Err_Code,
  output logic [7:0] Cycle_Count
);

  localparam logic [CW-1:0] R_LEN_C = CW'(R_LEN);
  localparam logic [CW-1:0] G_LEN_C = CW'(G_LEN);
  localparam logic [CW-1:0] Y_LEN_C = CW'(Y_LEN);

  state_t        r_state;
  logic [2:0]    r_lamp;
  logic          r_phase_done;
  logic          r_error;
  logic [2:0]    r_err_code;
  logic [7:0]    r_cycle_count;

  logic [2:0]    w_lamp;
  logic          w_valid;
  logic          w_same;
  logic          w_order_ok;
  logic          w_in_chk;
  logic          w_tracking;
  logic [CW-1:0] w_len;
  logic [CW-1:0] w_exp_len;
  logic          w_short;
  logic          w_at_limit;
  logic          w_tmr_load;
  logic          w_tmr_inc;

  assign w_lamp     = {Red, Green, Yellow};
  assign w_valid    = $onehot(w_lamp);
  assign w_same     = (w_lamp == r_lamp);
  assign w_order_ok = (w_lamp == next_lamp(r_lamp));
  assign w_in_chk   = (r_state == ST_CHK_R) || (r_state == ST_CHK_G) ||
                      (r_state == ST_CHK_Y);
  assign w_tracking = w_in_chk || (r_state == ST_ACQ);

  always_comb begin
    w_exp_len = R_LEN_C;
    case (r_state)
      ST_CHK_G: w_exp_len = G_LEN_C;
      ST_CHK_Y: w_exp_len = Y_LEN_C;
      default:  w_exp_len = R_LEN_C;
    endcase
  end

  assign w_short    = (w_len < w_exp_len);
  assign w_at_limit = (w_len == w_exp_len);

  // A new phase (first sample or any lamp change) restarts the count at 1;
  // the value loaded on a faulting change is never looked at again.
  assign w_tmr_load = !Clear && w_valid &&
                      ((r_state == ST_IDLE) || (w_tracking && !w_same));
  assign w_tmr_inc  = !Clear && w_valid && w_tracking && w_same;

  phase_timer #(
    .CW (CW)
  ) u_phase_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_clr   (Clear),
    .i_load  (w_tmr_load),
    .i_inc   (w_tmr_inc),
    .o_count (w_len)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state       <= ST_IDLE;
      r_lamp        <= 3'b000;
      r_phase_done  <= 1'b0;
      r_error       <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_cycle_count <= 8'd0;
    end else begin
      r_phase_done <= 1'b0;
      if (Clear) begin
        r_state    <= ST_IDLE;
        r_error    <= 1'b0;
        r_err_code <= ERR_NONE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!w_valid) begin
              r_state    <= ST_FAULT;
              r_error    <= 1'b1;
              r_err_code <= ERR_ENC;
            end else begin
              r_state <= ST_ACQ;
              r_lamp  <= w_lamp;
            end
          end
          ST_ACQ: begin
            if (!w_valid) begin
              r_state    <= ST_FAULT;
              r_error    <= 1'b1;
              r_err_code <= ERR_ENC;
            end else if (!w_same) begin
              if (!w_order_ok) begin
                r_state    <= ST_FAULT;
                r_error    <= 1'b1;
                r_err_code <= ERR_ORDER;
              end else begin
                r_state <= chk_state(w_lamp);
                r_lamp  <= w_lamp;
              end
            end
          end
          ST_CHK_R, ST_CHK_G, ST_CHK_Y: begin
            // Priority within one sample: encoding, order, short, long.
            if (!w_valid) begin
              r_state    <= ST_FAULT;
              r_error    <= 1'b1;
              r_err_code <= ERR_ENC;
            end else if (w_same) begin
              if (w_at_limit) begin
                r_state    <= ST_FAULT;
                r_error    <= 1'b1;
                r_err_code <= ERR_LONG;
              end
            end else if (!w_order_ok) begin
              r_state    <= ST_FAULT;
              r_error    <= 1'b1;
              r_err_code <= ERR_ORDER;
            end else if (w_short) begin
              r_state    <= ST_FAULT;
              r_error    <= 1'b1;
              r_err_code <= ERR_SHORT;
            end else begin
              r_phase_done <= 1'b1;
              r_state      <= chk_state(w_lamp);
              r_lamp       <= w_lamp;
              if (r_state == ST_CHK_Y) begin
                r_cycle_count <= r_cycle_count + 8'd1;
              end
            end
          end
          ST_FAULT: begin
            r_state <= ST_FAULT;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign Phase_Done  = r_phase_done;
  assign Error       = r_error;
  assign Err_Code    = r_err_code;
  assign Cycle_Count = r_cycle_count;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed, table-driven bench for traffic_light_monitor with default lengths
// R=4, G=5, Y=2, plus hand sequences for async reset and Cycle_Count wrap.
module tb_traffic_light_monitor;

  localparam logic [2:0] L_R   = 3'b100;
  localparam logic [2:0] L_G   = 3'b010;
  localparam logic [2:0] L_Y   = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  typedef struct packed {
    logic [63:0] tag;
    logic        clr;
    logic [2:0]  lamp;
    logic        pd;
    logic        err;
    logic [2:0]  code;
    logic [7:0]  cnt;
  } vec_t;

  logic       Clock;
  logic       Reset;
  logic       Red, Green, Yellow;
  logic       Clear;
  logic       Phase_Done;
  logic       Error;
  logic [2:0] Err_Code;
  logic [7:0] Cycle_Count;

  vec_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  traffic_light_monitor #(
    .R_LEN (4),
    .G_LEN (5),
    .Y_LEN (2),
    .CW    (4)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Red         (Red),
    .Green       (Green),
    .Yellow      (Yellow),
    .Clear       (Clear),
    .Phase_Done  (Phase_Done),
    .Error       (Error),
    .Err_Code    (Err_Code),
    .Cycle_Count (Cycle_Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input logic [63:0] tag, input logic pd, input logic err,
                       input logic [2:0] code, input logic [7:0] cnt);
    n_vec++;
    if ({Phase_Done, Error, Err_Code, Cycle_Count} !== {pd, err, code, cnt}) begin
      n_miss++;
      $display("FAIL %0s (vec %0d): got pd=%b err=%b code=%0d cnt=%0d, want pd=%b err=%b code=%0d cnt=%0d",
               tag, n_vec, Phase_Done, Error, Err_Code, Cycle_Count, pd, err, code, cnt);
    end
  endtask

  task automatic apply(input vec_t v);
    Clear = v.clr;
    {Red, Green, Yellow} = v.lamp;
    @(posedge Clock);
    #1;
    check(v.tag, v.pd, v.err, v.code, v.cnt);
  endtask

  task automatic add(input logic [63:0] tag, input logic clr, input logic [2:0] l,
                     input logic pd, input logic err, input logic [2:0] code,
                     input logic [7:0] cnt);
    vec_t v;
    v.tag = tag; v.clr = clr; v.lamp = l; v.pd = pd;
    v.err = err; v.code = code; v.cnt = cnt;
    q.push_back(v);
  endtask

  // n samples of one lamp, no error; only the first sample may carry Phase_Done.
  task automatic add_run(input logic [63:0] tag, input logic [2:0] l, input int n,
                         input logic pd_first, input logic [7:0] cnt);
    for (int i = 0; i < n; i++) add(tag, 1'b0, l, (i == 0) ? pd_first : 1'b0, 1'b0, 3'd0, cnt);
  endtask

  task automatic step(input logic [63:0] tag, input logic [2:0] l, input logic pd,
                      input logic [7:0] cnt);
    vec_t v;
    v.tag = tag; v.clr = 1'b0; v.lamp = l; v.pd = pd;
    v.err = 1'b0; v.code = 3'd0; v.cnt = cnt;
    apply(v);
  endtask

  task automatic drive(input logic [2:0] l, input int n);
    Clear = 1'b0;
    {Red, Green, Yellow} = l;
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b0;
    Clear = 1'b0;
    {Red, Green, Yellow} = L_R;

    // Nominal: first R is acquisition, Phase_Done on every later change.
    add_run("nom_r0", L_R, 4, 1'b0, 8'd0);
    add_run("nom_g0", L_G, 5, 1'b0, 8'd0);
    add_run("nom_y0", L_Y, 2, 1'b1, 8'd0);
    add_run("nom_r1", L_R, 4, 1'b1, 8'd1);
    add_run("nom_g1", L_G, 5, 1'b1, 8'd1);
    add_run("nom_y1", L_Y, 2, 1'b1, 8'd1);
    add_run("nom_r2", L_R, 4, 1'b1, 8'd2);
    add_run("nom_g2", L_G, 5, 1'b1, 8'd2);
    add_run("nom_y2", L_Y, 2, 1'b1, 8'd2);
    add("nom_clr", 1'b1, L_OFF, 1'b0, 1'b0, 3'd0, 8'd2);
    // Short yellow, then later faults must not overwrite the code.
    add_run("sh_r", L_R, 4, 1'b0, 8'd2);
    add_run("sh_g", L_G, 5, 1'b0, 8'd2);
    add_run("sh_y", L_Y, 1, 1'b1, 8'd2);
    add("sh_flt",  1'b0, L_R,   1'b0, 1'b1, 3'd3, 8'd2);
    add("sh_hold", 1'b0, L_OFF, 1'b0, 1'b1, 3'd3, 8'd2);
    add("sh_hld2", 1'b0, L_G,   1'b0, 1'b1, 3'd3, 8'd2);
    add("sh_clr",  1'b1, L_OFF, 1'b0, 1'b0, 3'd0, 8'd2);
    // Long yellow fires on the 3rd Y sample.
    add_run("lg_r", L_R, 4, 1'b0, 8'd2);
    add_run("lg_g", L_G, 5, 1'b0, 8'd2);
    add_run("lg_y", L_Y, 2, 1'b1, 8'd2);
    add("lg_flt", 1'b0, L_Y,   1'b0, 1'b1, 3'd4, 8'd2);
    add("lg_clr", 1'b1, L_OFF, 1'b0, 1'b0, 3'd0, 8'd2);
    // Order fault R->Y during acquisition.
    add_run("or_r", L_R, 2, 1'b0, 8'd2);
    add("or_flt",  1'b0, L_Y,    1'b0, 1'b1, 3'd2, 8'd2);
    add("or_hold", 1'b0, 3'b011, 1'b0, 1'b1, 3'd2, 8'd2);
    add("or_clr",  1'b1, L_OFF,  1'b0, 1'b0, 3'd0, 8'd2);
    // Encoding fault: Red and Green together mid-green.
    add_run("en_r", L_R, 4, 1'b0, 8'd2);
    add_run("en_g", L_G, 2, 1'b0, 8'd2);
    add("en_flt",  1'b0, 3'b110, 1'b0, 1'b1, 3'd1, 8'd2);
    add("en_hold", 1'b0, L_Y,    1'b0, 1'b1, 3'd1, 8'd2);
    add("en_clr",  1'b1, L_OFF,  1'b0, 1'b0, 3'd0, 8'd2);
    add("en_idle", 1'b0, L_OFF,  1'b0, 1'b1, 3'd1, 8'd2);
    add("en_clr2", 1'b1, L_OFF,  1'b0, 1'b0, 3'd0, 8'd2);
    // Clear on the same edge as a too-short green -> no error latched.
    add_run("cs_r", L_R, 4, 1'b0, 8'd2);
    add_run("cs_g", L_G, 3, 1'b0, 8'd2);
    add("cs_both", 1'b1, L_Y,   1'b0, 1'b0, 3'd0, 8'd2);
    add("cs_acq",  1'b0, L_Y,   1'b0, 1'b0, 3'd0, 8'd2);
    add("cs_acq2", 1'b0, L_Y,   1'b0, 1'b0, 3'd0, 8'd2);
    add("cs_chkr", 1'b0, L_R,   1'b0, 1'b0, 3'd0, 8'd2);
    add("cs_clr",  1'b1, L_OFF, 1'b0, 1'b0, 3'd0, 8'd2);
    // Length saturates during a long acquisition phase.
    add_run("sat_r", L_R, 17, 1'b0, 8'd2);
    add_run("sat_g", L_G, 5,  1'b0, 8'd2);
    add_run("sat_y", L_Y, 1,  1'b1, 8'd2);
    add("sat_clr", 1'b1, L_OFF, 1'b0, 1'b0, 3'd0, 8'd2);
    // Long red in a checked phase fires on the 5th R sample.
    add_run("lr_r0", L_R, 4, 1'b0, 8'd2);
    add_run("lr_g",  L_G, 5, 1'b0, 8'd2);
    add_run("lr_y",  L_Y, 2, 1'b1, 8'd2);
    add_run("lr_r1", L_R, 4, 1'b1, 8'd3);
    add("lr_flt", 1'b0, L_R,   1'b0, 1'b1, 3'd4, 8'd3);
    add("lr_clr", 1'b1, L_OFF, 1'b0, 1'b0, 3'd0, 8'd3);

    repeat (2) @(posedge Clock);
    #1;
    check("reset", 1'b0, 1'b0, 3'd0, 8'd0);
    Reset = 1'b1;

    for (int i = 0; i < q.size(); i++) apply(q[i]);

    // Async reset while Phase_Done is high mid-green; count is nonzero.
    step("ar_r0", L_R, 1'b0, 8'd3);
    drive(L_R, 3);
    step("ar_g0", L_G, 1'b0, 8'd3);
    drive(L_G, 4);
    step("ar_y",  L_Y, 1'b1, 8'd3);
    drive(L_Y, 1);
    step("ar_r1", L_R, 1'b1, 8'd4);
    drive(L_R, 3);
    step("ar_g1", L_G, 1'b1, 8'd4);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    check("async_rst", 1'b0, 1'b0, 3'd0, 8'd0);
    #3;
    Reset = 1'b1;

    // 256 good cycles wrap Cycle_Count back to 0.
    drive(L_R, 4);
    for (int i = 0; i < 256; i++) begin
      drive(L_G, 5);
      drive(L_Y, 2);
      drive(L_R, 4);
      if (i == 0 || i == 254 || i == 255)
        check("wrap", 1'b0, 1'b0, 3'd0, 8'(i + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
